// File: rtl/vga_tile_engine.sv
// VGA timing generator, tile-map fetch and palette pipeline; pixels reach the pins 2 pixel periods after their counters.
// Optional macro VGA_SCORE_BAR_EN: yellow score bar over the top 8 active lines.
module vga_tile_engine #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIX_DIV    = 1,
  parameter int TILE_SHIFT = 5,
  parameter int GRID_COLS  = 20,
  parameter int GRID_ROWS  = 15,
  parameter int ADDR_W     = 9,
  parameter int TILE_W     = 2,
  parameter int CB         = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TILE_W-1:0] tile_rdata,
  input  logic [9:0]        score,
  output logic              re,
  output logic [ADDR_W-1:0] raddr,
  output logic [CB-1:0]     R_out,
  output logic [CB-1:0]     G_out,
  output logic [CB-1:0]     B_out,
  output logic              HSync,
  output logic              VSync,
  output logic              vblank_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

  logic [DIV_W-1:0]  div;
  logic [H_W-1:0]    hcnt;
  logic [V_W-1:0]    vcnt;
  logic [ADDR_W-1:0] raddr_q;
  logic              pe;
  logic [31:0]       h_int, v_int;
  logic              active0, in_grid0, hs_raw0, vs_raw0;
  logic [ADDR_W-1:0] addr0;
  logic              s1_active, s1_in_grid, s1_hs, s1_vs;
  logic [CB-1:0]     col_r, col_g, col_b;

  assign pe    = (32'(div) == PIX_DIV - 1);
  assign h_int = 32'(hcnt);
  assign v_int = 32'(vcnt);

  assign active0  = (h_int < H_ACTIVE) && (v_int < V_ACTIVE);
  assign in_grid0 = active0 && ((h_int >> TILE_SHIFT) < GRID_COLS) &&
                    ((v_int >> TILE_SHIFT) < GRID_ROWS);
  assign hs_raw0  = (h_int >= H_ACTIVE + H_FP) && (h_int < H_ACTIVE + H_FP + H_SYNC);
  assign vs_raw0  = (v_int >= V_ACTIVE + V_FP) && (v_int < V_ACTIVE + V_FP + V_SYNC);
  assign addr0    = ADDR_W'((v_int >> TILE_SHIFT) * GRID_COLS + (h_int >> TILE_SHIFT));

  // Gated by reset so a held reset never fetches or signals vblank from the parked counters.
  assign re           = reset && pe && in_grid0;
  assign raddr        = re ? addr0 : raddr_q;
  assign vblank_start = reset && pe && (hcnt == '0) && (v_int == V_ACTIVE);

`ifdef VGA_SCORE_BAR_EN
  logic bar0, s1_bar;
  assign bar0 = (v_int < 8) && (h_int < {20'd0, score, 2'b00});
`else
  logic unused_score;
  assign unused_score = ^score;
`endif

  always_comb begin
    col_r = '0;
    col_g = '0;
    col_b = '0;
    if (s1_active && s1_in_grid) begin
      case (tile_rdata)
        TILE_W'(0): col_b = '0;
        TILE_W'(1): col_g = '1;
        TILE_W'(2): col_r = '1;
        TILE_W'(3): begin
          col_r = '1;
          col_g = '1;
          col_b = '1;
        end
        default: col_b = '1;
      endcase
    end
`ifdef VGA_SCORE_BAR_EN
    if (s1_active && s1_bar) begin
      col_r = '1;
      col_g = '1;
      col_b = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div        <= '0;
      hcnt       <= '0;
      vcnt       <= '0;
      raddr_q    <= '0;
      s1_active  <= 1'b0;
      s1_in_grid <= 1'b0;
      s1_hs      <= 1'b0;
      s1_vs      <= 1'b0;
`ifdef VGA_SCORE_BAR_EN
      s1_bar     <= 1'b0;
`endif
      R_out      <= '0;
      G_out      <= '0;
      B_out      <= '0;
      HSync      <= ~SYNC_POL;
      VSync      <= ~SYNC_POL;
    end else begin
      div <= pe ? '0 : div + 1'b1;
      if (re) raddr_q <= addr0;
      if (pe) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
        s1_active  <= active0;
        s1_in_grid <= in_grid0;
        s1_hs      <= hs_raw0;
        s1_vs      <= vs_raw0;
`ifdef VGA_SCORE_BAR_EN
        s1_bar     <= bar0;
`endif
        // tile_rdata belongs to the stage-1 pixel: the RAM holds it until the next re lands.
        R_out <= col_r;
        G_out <= col_g;
        B_out <= col_b;
        HSync <= s1_hs ? SYNC_POL : ~SYNC_POL;
        VSync <= s1_vs ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

endmodule

// File: tb/tb_vga_tile_engine.sv
// Bench for vga_tile_engine on a reduced timing set; a pixel-index reference model predicts every clock.
// Bar expectations follow VGA_SCORE_BAR_EN in the same way as the design.
module tb_vga_tile_engine;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int D  = 2;
  localparam int TS = 3;
  localparam int GC = 6, GR = 5;
  localparam int AW = 9, TW = 3, CB = 4;
  localparam bit SP = 1'b0;
  localparam int FR = HT * VT * D;
  localparam int EXP_RE = 48 * 40;
  localparam int VW = 2 + 3 * CB + 2;
`ifdef VGA_SCORE_BAR_EN
  localparam bit BAR = 1'b1;
`else
  localparam bit BAR = 1'b0;
`endif
  localparam logic [CB-1:0] F = '1;
  localparam logic [CB-1:0] Z = '0;
  localparam logic [3*CB-1:0] BLACK = {Z, Z, Z}, GREEN = {Z, F, Z}, RED = {F, Z, Z};
  localparam logic [3*CB-1:0] WHITE = {F, F, F}, BLUE = {Z, Z, F}, YELLOW = {F, F, Z};
  localparam logic [VW-1:0] RST_VEC = {2'b00, BLACK, !SP, !SP};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0;
  logic [TW-1:0] tile_rdata = '0;
  logic [9:0]    score = '0;
  logic          re, HSync, VSync, vblank_start;
  logic [AW-1:0] raddr;
  logic [CB-1:0] R_out, G_out, B_out;

  int checks = 0;
  int errors = 0;
  int score_v = 0;
  int exp_raddr = 0;
  logic [TW-1:0] mem [0:GC*GR-1];

  vga_tile_engine #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(SP), .PIX_DIV(D), .TILE_SHIFT(TS),
    .GRID_COLS(GC), .GRID_ROWS(GR), .ADDR_W(AW), .TILE_W(TW), .CB(CB)
  ) dut (
    .clk(clk), .reset(reset), .tile_rdata(tile_rdata), .score(score),
    .re(re), .raddr(raddr), .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .HSync(HSync), .VSync(VSync), .vblank_start(vblank_start)
  );

  // Game-state RAM: one clock read latency, data held until the next read.
  always @(posedge clk)
    if (re === 1'b1) tile_rdata <= (int'(raddr) < GC * GR) ? mem[int'(raddr)] : 'x;

  function automatic bit in_grid(int h, int v);
    return h < HA && v < VA && (h >> TS) < GC && (v >> TS) < GR;
  endfunction

  function automatic logic [3*CB-1:0] colour(int h, int v);
    int code;
    if (!(h < HA && v < VA)) return BLACK;
    if (BAR && v < 8 && h < score_v * 4) return YELLOW;
    if (!in_grid(h, v)) return BLACK;
    code = int'(mem[(v >> TS) * GC + (h >> TS)]);
    if (code == 0) return BLACK;
    if (code == 1) return GREEN;
    if (code == 2) return RED;
    if (code == 3) return WHITE;
    return BLUE;
  endfunction

  // Clock t counts from the first clock after reset release; pixel index q = t / D.
  function automatic logic [VW-1:0] model(input int t, output int addr);
    int q, h, v, p, hp, vp;
    logic pe_e, re_e, vb_e, hs, vs;
    logic [3*CB-1:0] c;
    q = t / D;
    h = q % HT;
    v = (q / HT) % VT;
    pe_e = (t % D) == D - 1;
    re_e = pe_e && in_grid(h, v);
    addr = re_e ? (v >> TS) * GC + (h >> TS) : -1;
    vb_e = pe_e && h == 0 && v == VA;
    c = BLACK;
    hs = !SP;
    vs = !SP;
    if (q >= 2) begin
      p = q - 2;
      hp = p % HT;
      vp = (p / HT) % VT;
      hs = (hp >= HA + HF && hp < HA + HF + HS) ? SP : !SP;
      vs = (vp >= VA + VF && vp < VA + VF + VS) ? SP : !SP;
      c = colour(hp, vp);
    end
    return {re_e, vb_e, c, hs, vs};
  endfunction

  function automatic int tpix(int h, int v);
    return ((v * HT + h) + 2) * D;
  endfunction

  task automatic apply_reset();
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_raddr = 0;
  endtask

  task automatic load_pattern();
    for (int i = 0; i < GC * GR; i++) mem[i] = '0;
    mem[0] = 3'd1; mem[2] = 3'd4; mem[3] = 3'd3; mem[4] = 3'd1; mem[5] = 3'd3;
    mem[GC + 1] = 3'd2;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({re, vblank_start, R_out, G_out, B_out, HSync, VSync} !== RST_VEC || raddr !== '0) begin
        errors++;
        $display("FAIL reset_state got %h/%h exp %h/0", {re, vblank_start, R_out, G_out, B_out, HSync, VSync}, raddr, RST_VEC);
      end
    end
  endtask

  task automatic test_tile_pattern();
    int sh[10] = '{0, 7, 8, 8, 16, 24, 50, 0, 0, 70};
    int sv[10] = '{0, 7, 8, 0, 0, 0, 0, 44, 48, 0};
    logic [3*CB-1:0] sc[10] = '{GREEN, GREEN, RED, BLACK, BLUE, WHITE, BLACK, BLACK, BLACK, BLACK};
    logic [VW-1:0] vec;
    int a, nre, nvb;
    load_pattern();
    score_v = 0;
    score = '0;
    apply_reset();
    nre = 0;
    nvb = 0;
    for (int t = 0; t < FR + 4 * D; t++) begin
      vec = model(t, a);
      if (a >= 0) exp_raddr = a;
      checks++;
      if ({re, vblank_start, R_out, G_out, B_out, HSync, VSync} !== vec || raddr !== AW'(exp_raddr)) begin
        errors++;
        if (errors < 20) $display("FAIL pattern t=%0d got %h/%0d exp %h/%0d", t, {re, vblank_start, R_out, G_out, B_out, HSync, VSync}, raddr, vec, exp_raddr);
      end
      for (int k = 0; k < 10; k++)
        if (t == tpix(sh[k], sv[k])) begin
          checks++;
          if ({R_out, G_out, B_out} !== sc[k]) begin
            errors++;
            $display("FAIL pattern_pixel (%0d,%0d) got %h exp %h", sh[k], sv[k], {R_out, G_out, B_out}, sc[k]);
          end
        end
      if (t < FR && re === 1'b1) nre++;
      if (t < FR && vblank_start === 1'b1) nvb++;
      @(negedge clk);
    end
    checks++;
    if (nre != EXP_RE) begin
      errors++;
      $display("FAIL re_per_frame got %0d exp %0d", nre, EXP_RE);
    end
    checks++;
    if (nvb != 1) begin
      errors++;
      $display("FAIL vblank_per_frame got %0d exp 1", nvb);
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] vec;
    int a, nre;
    for (int it = 0; it < 2; it++) begin
      for (int i = 0; i < GC * GR; i++) mem[i] = TW'($urandom_range(0, 7));
      score_v = $urandom_range(0, 20);
      score = 10'(score_v);
      apply_reset();
      nre = 0;
      for (int t = 0; t < FR + 4 * D; t++) begin
        vec = model(t, a);
        if (a >= 0) exp_raddr = a;
        checks++;
        if ({re, vblank_start, R_out, G_out, B_out, HSync, VSync} !== vec || raddr !== AW'(exp_raddr)) begin
          errors++;
          if (errors < 20) $display("FAIL random_frame t=%0d got %h/%0d exp %h/%0d", t, {re, vblank_start, R_out, G_out, B_out, HSync, VSync}, raddr, vec, exp_raddr);
        end
        if (t < FR && re === 1'b1) nre++;
        @(negedge clk);
      end
      checks++;
      if (nre != EXP_RE) begin
        errors++;
        $display("FAIL random_re_count got %0d exp %0d", nre, EXP_RE);
      end
    end
  endtask

  task automatic test_score_bar();
    int sh[3], sv[3];
    logic [3*CB-1:0] sc[3];
    logic [VW-1:0] vec;
    int a;
    load_pattern();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        score_v = 10;
        sh = '{39, 40, 0};  sv = '{0, 0, 7};
        sc = '{BAR ? YELLOW : GREEN, WHITE, BAR ? YELLOW : GREEN};
      end else begin
        score_v = 1023;
        sh = '{63, 63, 48}; sv = '{7, 8, 0};
        sc = '{BAR ? YELLOW : BLACK, BLACK, BAR ? YELLOW : BLACK};
      end
      score = 10'(score_v);
      apply_reset();
      for (int t = 0; t < (10 * HT + 4) * D; t++) begin
        vec = model(t, a);
        if (a >= 0) exp_raddr = a;
        checks++;
        if ({re, vblank_start, R_out, G_out, B_out, HSync, VSync} !== vec || raddr !== AW'(exp_raddr)) begin
          errors++;
          if (errors < 20) $display("FAIL score_bar t=%0d got %h exp %h", t, {re, vblank_start, R_out, G_out, B_out, HSync, VSync}, vec);
        end
        for (int k = 0; k < 3; k++)
          if (t == tpix(sh[k], sv[k])) begin
            checks++;
            if ({R_out, G_out, B_out} !== sc[k]) begin
              errors++;
              $display("FAIL bar_pixel score=%0d (%0d,%0d) got %h exp %h", score_v, sh[k], sv[k], {R_out, G_out, B_out}, sc[k]);
            end
          end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_midframe_reset();
    logic [VW-1:0] vec;
    int a;
    load_pattern();
    score_v = 0;
    score = '0;
    apply_reset();
    for (int t = 0; t < (10 * HT + 30) * D + D - 1; t++) begin
      vec = model(t, a);
      if (a >= 0) exp_raddr = a;
      checks++;
      if ({re, vblank_start, R_out, G_out, B_out, HSync, VSync} !== vec) begin
        errors++;
        if (errors < 20) $display("FAIL pre_reset t=%0d got %h exp %h", t, {re, vblank_start, R_out, G_out, B_out, HSync, VSync}, vec);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({re, vblank_start, R_out, G_out, B_out, HSync, VSync} !== RST_VEC || raddr !== '0) begin
        errors++;
        $display("FAIL midframe_reset got %h/%0d exp %h/0", {re, vblank_start, R_out, G_out, B_out, HSync, VSync}, raddr, RST_VEC);
      end
    end
    reset = 1'b1;
    exp_raddr = 0;
    for (int t = 0; t < 3 * HT * D; t++) begin
      vec = model(t, a);
      if (a >= 0) exp_raddr = a;
      checks++;
      if ({re, vblank_start, R_out, G_out, B_out, HSync, VSync} !== vec || raddr !== AW'(exp_raddr)) begin
        errors++;
        if (errors < 20) $display("FAIL post_reset t=%0d got %h exp %h", t, {re, vblank_start, R_out, G_out, B_out, HSync, VSync}, vec);
      end
      if (t == tpix(0, 0)) begin
        checks++;
        if ({R_out, G_out, B_out} !== GREEN) begin
          errors++;
          $display("FAIL restart_pixel00 got %h exp %h", {R_out, G_out, B_out}, GREEN);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_tile_pattern();
    test_back_to_back();
    test_score_bar();
    test_midframe_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
